// File: rtl/serial_adder_pkg.sv
// Shared types for serial_adder: FSM state encoding and default operand width.
// Imported by the top; the per-bit adder cell needs nothing from here.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder, purely combinational (zero latency, no flow control).
// Serial_adder reuses this single cell for every bit position, one bit per cycle.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: result and done appear WIDTH+1 edges after start is first seen; start is ignored while busy.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             accept;
   logic             step;
   logic             last_bit;
   logic             fa_sum;
   logic             fa_cout;

   assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

   full_adder_1bit u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q == RUN);
      done   = (state_q == DONE);
      step   = (state_q == RUN);
      accept = start && ((state_q == IDLE) || (state_q == DONE));
   end

   // Visible sum/cout are loaded only on the final bit so they stay stable while the
   // internal result register is still filling from the MSB side.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      if (accept) begin
         a_d     = a;
         b_d     = b;
         carry_d = cin;
         res_d   = '0;
         cnt_d   = '0;
      end else if (step) begin
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         carry_d = fa_cout;
         res_d   = {fa_sum, res_q[WIDTH-1:1]};
         cnt_d   = cnt_q + CW'(1);
         if (last_bit) begin
            sum_d  = {fa_sum, res_q[WIDTH-1:1]};
            cout_d = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_d  = carry_q ^ fa_cout;
`endif
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus hand-written multi-cycle sequences.
module tb_serial_adder;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Launch one operation, scramble inputs after capture, and check latency, result and holding.
   task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         input logic [7:0] es, input logic ec, input logic eo, input string nm);
      int         edges;
      logic       stable;
      logic       busy_ok;
      logic [7:0] held;
      @(negedge clock);
      start = 1'b1; a = va; b = vb; cin = vc;
      held = sum;
      edges = 0; stable = 1'b1; busy_ok = 1'b1;
      do begin
         @(negedge clock);
         edges++;
         start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
         if (!done) begin
            if (sum !== held) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
         end else if (busy !== 1'b0) begin
            busy_ok = 1'b0;
         end
      end while (!done && edges < 40);
      check({nm, " latency"}, edges, 9);
      check({nm, " sum"}, sum, es);
      check({nm, " cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
      check({nm, " ovf"}, ovf, eo);
`else
      if (eo === 1'bx) $display("note: %s", nm);
`endif
      check({nm, " sum stable in RUN"}, stable, 1);
      check({nm, " busy in RUN only"}, busy_ok, 1);
      repeat (3) @(negedge clock);
      check({nm, " done one pulse"}, {busy, done}, 2'b00);
      check({nm, " sum held in IDLE"}, {cout, sum}, {ec, es});
   endtask

   int         edges;
   int         ndone;
   int         t1, t2;
   logic [7:0] s1, s2;

   initial begin
      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

      reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
      repeat (3) @(negedge clock);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("reset ovf", ovf, 0);
`endif
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov,
                $sformatf("vec%0d", i));
      end

      // start pulsed mid-RUN must be ignored
      @(negedge clock);
      start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
      edges = 0; ndone = 0; t1 = 0; s1 = 8'h00;
      repeat (20) begin
         @(negedge clock);
         edges++;
         if (done) begin
            ndone++;
            if (t1 == 0) begin t1 = edges; s1 = sum; end
         end
         start = (edges == 3);
         if (edges == 3) begin a = 8'hAA; b = 8'h33; end
      end
      check("ignore start: done count", ndone, 1);
      check("ignore start: latency", t1, 9);
      check("ignore start: sum", s1, 8'h10);

      // reset mid-RUN aborts with no done
      @(negedge clock);
      start = 1'b1; a = 8'h55; b = 8'h11; cin = 1'b0;
      edges = 0;
      while (edges < 4) begin
         @(negedge clock);
         edges++;
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort sum", sum, 0);
      check("abort cout", cout, 0);
      ndone = 0;
      repeat (12) begin
         @(negedge clock);
         if (done) ndone++;
      end
      check("abort no done", ndone, 0);
      run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after abort");

      // reset wins over start in the same cycle
      @(negedge clock);
      reset = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
      @(negedge clock);
      reset = 1'b0; start = 1'b0;
      check("reset priority busy", busy, 0);
      @(negedge clock);
      check("reset priority stays idle", {busy, done}, 2'b00);

      // start held high through DONE: back-to-back operations
      @(negedge clock);
      start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
      edges = 0; t1 = 0; t2 = 0; s1 = 8'h00; s2 = 8'h00;
      repeat (30) begin
         @(negedge clock);
         edges++;
         if (edges == 1) begin a = 8'h10; b = 8'h20; end
         if (done) begin
            if (t1 == 0) begin t1 = edges; s1 = sum; end
            else if (t2 == 0) begin t2 = edges; s2 = sum; end
         end
         if (t1 != 0 && edges == t1 + 1) start = 1'b0;
      end
      check("b2b first latency", t1, 9);
      check("b2b first sum", s1, 8'h07);
      check("b2b gap", t2 - t1, 9);
      check("b2b second sum", s2, 8'h30);
      check("b2b back to idle", {busy, done}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
